// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - master handshake and RAM port bundle for mem_arbiter
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16
);
    logic                  m0_req;
    logic                  m0_we;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic                  m0_gnt;
    logic                  m0_ack;
    logic                  m1_req;
    logic                  m1_we;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic                  m1_gnt;
    logic                  m1_ack;
    logic [DATA_WIDTH-1:0] rdata;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_data;
    logic                  ram_rden;
    logic                  ram_wren;
    logic [DATA_WIDTH-1:0] ram_q;
    logic                  busy;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  ram_q,
        output m0_gnt, m0_ack, m1_gnt, m1_ack,
        output rdata, ram_addr, ram_data, ram_rden, ram_wren, busy
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output ram_q,
        input  m0_gnt, m0_ack, m1_gnt, m1_ack,
        input  rdata, ram_addr, ram_data, ram_rden, ram_wren, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master arbiter for a single-port BRAM with fixed read latency
// Optional MEM_ARB_FIXED_PRIORITY_EN: master 0 always wins a tie instead of round-robin.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 20,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic clk,
    input  logic reset_n,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  we_q, we_d;
    logic [1:0]            gnt_q, gnt_d;
    logic [1:0]            ack_q, ack_d;
    logic                  rden_q, rden_d;
    logic                  wren_q, wren_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic [1:0]            req;
    logic                  win;

    assign req = {bus.m1_req, bus.m0_req};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            gnt_q        <= 2'b00;
            ack_q        <= 2'b00;
            rden_q       <= 1'b0;
            wren_q       <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            rdata_q      <= '0;
            cnt_q        <= 2'd0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            gnt_q        <= gnt_d;
            ack_q        <= ack_d;
            rden_q       <= rden_d;
            wren_q       <= wren_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            rdata_q      <= rdata_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
        end
    end

    // Strobes and ack are computed one state early so every output leaves a flop.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        gnt_d        = gnt_q;
        ack_d        = 2'b00;
        rden_d       = 1'b0;
        wren_d       = 1'b0;
        addr_d       = addr_q;
        data_d       = data_q;
        rdata_d      = rdata_q;
        cnt_d        = cnt_q;
        win          = 1'b0;
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
`ifdef MEM_ARB_FIXED_PRIORITY_EN
                    win = ~req[0];
`else
                    win = (req == 2'b11) ? ~last_grant_q : req[1];
`endif
                    last_grant_d = win;
                    we_d         = win ? bus.m1_we    : bus.m0_we;
                    addr_d       = win ? bus.m1_addr  : bus.m0_addr;
                    data_d       = win ? bus.m1_wdata : bus.m0_wdata;
                    gnt_d        = win ? 2'b10 : 2'b01;
                    wren_d       = we_d;
                    rden_d       = ~we_d;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    ack_d   = gnt_q;
                    state_d = DONE;
                end else begin
                    cnt_d   = 2'(READ_LATENCY);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 2'd1) begin
                    rdata_d = bus.ram_q;
                    ack_d   = gnt_q;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            DONE: begin
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign bus.m0_gnt   = gnt_q[0];
    assign bus.m1_gnt   = gnt_q[1];
    assign bus.m0_ack   = ack_q[0];
    assign bus.m1_ack   = ack_q[1];
    assign bus.rdata    = rdata_q;
    assign bus.ram_addr = addr_q;
    assign bus.ram_data = data_q;
    assign bus.ram_rden = rden_q;
    assign bus.ram_wren = wren_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter at read latencies 1 and 3
module tb_mem_arbiter;
    localparam int AW = 20;
    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          sel;
    logic [1:0]    req, we;
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];

    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifa ();
    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifb ();

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ifa.slave));
    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(3)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ifb.slave));

    logic [DW-1:0] ram_q;
    assign ifa.m0_req = req[0] & ~sel;  assign ifb.m0_req = req[0] & sel;
    assign ifa.m1_req = req[1] & ~sel;  assign ifb.m1_req = req[1] & sel;
    assign ifa.m0_we = we[0];  assign ifb.m0_we = we[0];
    assign ifa.m1_we = we[1];  assign ifb.m1_we = we[1];
    assign ifa.m0_addr = addr[0];  assign ifb.m0_addr = addr[0];
    assign ifa.m1_addr = addr[1];  assign ifb.m1_addr = addr[1];
    assign ifa.m0_wdata = wdata[0];  assign ifb.m0_wdata = wdata[0];
    assign ifa.m1_wdata = wdata[1];  assign ifb.m1_wdata = wdata[1];
    assign ifa.ram_q = ram_q;  assign ifb.ram_q = ram_q;

    logic [1:0]    gnt, ack;
    logic [DW-1:0] rdata, ram_data;
    logic [AW-1:0] ram_addr;
    logic          rden, wren, busy;
    assign gnt      = sel ? {ifb.m1_gnt, ifb.m0_gnt} : {ifa.m1_gnt, ifa.m0_gnt};
    assign ack      = sel ? {ifb.m1_ack, ifb.m0_ack} : {ifa.m1_ack, ifa.m0_ack};
    assign rdata    = sel ? ifb.rdata    : ifa.rdata;
    assign ram_addr = sel ? ifb.ram_addr : ifa.ram_addr;
    assign ram_data = sel ? ifb.ram_data : ifa.ram_data;
    assign rden     = sel ? ifb.ram_rden : ifa.ram_rden;
    assign wren     = sel ? ifb.ram_wren : ifa.ram_wren;
    assign busy     = sel ? ifb.busy     : ifa.busy;

    // Environment BRAM: data appears RL cycles after the rden cycle.
    logic [DW-1:0] ram   [16];
    logic [DW-1:0] qpipe [3];
    always @(posedge clk) begin
        if (wren) ram[ram_addr[3:0]] <= ram_data;
        if (rden) qpipe[0] <= ram[ram_addr[3:0]];
        qpipe[1] <= qpipe[0];
        qpipe[2] <= qpipe[1];
    end
    assign ram_q = sel ? qpipe[2] : qpipe[0];

    int n_cmp = 0;
    int n_fail = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: t counts cycles after the sampling edge, L is the ack cycle.
    int            t = 0, L = 0, mw = 0, last = 1;
    logic          mwe = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_data = '0, exp_rdata = '0, rd_val = '0;
    logic [DW-1:0] refmem [16];

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                t = 0; last = 1; exp_addr = '0; exp_data = '0; exp_rdata = '0;
            end else if (t != 0) begin
                if (t == L) t = 0;
                else begin
                    t++;
                    if (t == L && !mwe) exp_rdata = rd_val;
                end
            end else if (req != 2'b00) begin
`ifdef MEM_ARB_FIXED_PRIORITY_EN
                mw = req[0] ? 0 : 1;
`else
                if (req == 2'b11) mw = (last == 1) ? 0 : 1;
                else mw = req[1] ? 1 : 0;
`endif
                last = mw;
                mwe = we[mw];
                exp_addr = addr[mw];
                exp_data = wdata[mw];
                L = mwe ? 2 : 2 + (sel ? 3 : 1);
                if (mwe) refmem[addr[mw][3:0]] = wdata[mw];
                else rd_val = refmem[addr[mw][3:0]];
                t = 1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (checking) begin
                chk("gnt", 32'(gnt), (t >= 1) ? ((mw == 1) ? 32'd2 : 32'd1) : 32'd0);
                chk("ack", 32'(ack), (t >= 1 && t == L) ? ((mw == 1) ? 32'd2 : 32'd1) : 32'd0);
                chk("ram_wren", 32'(wren), 32'(t == 1 && mwe));
                chk("ram_rden", 32'(rden), 32'(t == 1 && !mwe));
                chk("strobe_excl", 32'(rden & wren), 32'd0);
                chk("busy", 32'(busy), 32'(t >= 1));
                chk("ram_addr", 32'(ram_addr), 32'(exp_addr));
                chk("ram_data", 32'(ram_data), 32'(exp_data));
                chk("rdata", 32'(rdata), 32'(exp_rdata));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int            lat, nstb;
    logic [AW-1:0] sa;
    logic [DW-1:0] sd, rd;

    // Called one step after an edge while the arbiter is idle; returns ack cycle count.
    task automatic txn(input int m, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[m] = 1'b1; we[m] = w; addr[m] = a; wdata[m] = d;
        lat = 0; nstb = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (rden | wren) begin nstb++; sa = ram_addr; sd = ram_data; end
            if (ack[m]) begin lat = k; break; end
        end
        rd = rdata;
        req[m] = 1'b0;
        if (lat == 0) chk("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset(input logic s);
        reset_n = 1'b0;
        req = 2'b00;
        sel = s;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    int order [4];
    int nack, m1_acks, done_n;

    initial begin
        reset_n = 1'b1; sel = 1'b0; req = 2'b00; we = 2'b00;
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
        #2 reset_n = 1'b0;
        #1 checking = 1'b1;
        repeat (2) tick();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("reset_idle_out", {gnt, ack, rden, wren, busy}, 32'd0);
            chk("reset_idle_data", {rdata, ram_data}, 32'd0);
        end

        txn(0, 1'b1, 20'h00010, 16'hBEEF);
        chk("wr_latency", lat, 2);
        chk("wr_strobes", nstb, 1);
        chk("wr_addr", 32'(sa), 32'h00010);
        chk("wr_data", 32'(sd), 32'h0000BEEF);
        tick();
        txn(0, 1'b0, 20'h00010, 16'h0000);
        chk("rd_latency", lat, 3);
        chk("rd_data", 32'(rd), 32'h0000BEEF);
        chk("rd_strobes", nstb, 1);
        tick();

        do_reset(1'b0);
        we = 2'b00; addr[0] = 20'h00010; addr[1] = 20'h00010; req = 2'b11;
        nack = 0; m1_acks = 0;
        for (int k = 0; k < 100 && nack < 4; k++) begin
            tick();
            if (ack != 2'b00) begin
                order[nack] = ack[1] ? 1 : 0;
                if (ack[1]) m1_acks++;
                nack++;
                if (nack == 4) req = 2'b00;
            end
        end
        req = 2'b00;
        chk("contention_count", nack, 4);
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_FIXED_PRIORITY_EN
            chk("contention_order", order[k], 0);
`else
            chk("contention_order", order[k], k % 2);
`endif
        end
`ifdef MEM_ARB_FIXED_PRIORITY_EN
        chk("m1_starved", m1_acks, 0);
`endif
        repeat (2) tick();

        do_reset(1'b1);
        txn(0, 1'b1, 20'h00025, 16'h1234);
        chk("rl3_wr_latency", lat, 2);
        tick();
        txn(1, 1'b0, 20'h00025, 16'h0000);
        chk("rl3_rd_latency", lat, 5);
        chk("rl3_rd_data", 32'(rd), 32'h00001234);
        chk("rl3_rden_once", nstb, 1);
        tick();

        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 20'h00025;
        repeat (3) tick();
        chk("midread_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_gnt", 32'(gnt), 32'd0);
        chk("abort_ack", 32'(ack), 32'd0);
        req[0] = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        txn(0, 1'b0, 20'h00025, 16'h0000);
        chk("post_abort_latency", lat, 5);
        chk("post_abort_data", 32'(rd), 32'h00001234);
        tick();

        do_reset(1'b0);
        for (int i = 0; i < 16; i++) begin
            txn(0, 1'b1, 20'(i), 16'(i * 16'h1111 + 16'h0101));
            tick();
        end
        done_n = 0;
        for (int cyc = 0; cyc < 20000 && done_n < 200; cyc++) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                if (req[m] && ack[m]) begin
                    req[m] = 1'b0;
                    done_n++;
                end else if (!req[m] && $urandom_range(0, 2) == 0) begin
                    req[m]   = 1'b1;
                    we[m]    = 1'($urandom_range(0, 1));
                    addr[m]  = 20'($urandom_range(0, 15));
                    wdata[m] = 16'($urandom);
                end
            end
        end
        chk("random_done", done_n, 200);
        req = 2'b00;
        repeat (8) tick();

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port BRAM (single_port_ram) between two bus masters:
  - master 0: cpu;
  - master 1: a peripheral or DMA engine.
- Sits between the masters and the RAM port.
- Sequences each access: arbitration, one-cycle RAM strobe, fixed BRAM read-latency wait, registered response with a one-cycle ack.
- Guarantees at most one of ram_rden/ram_wren is ever active.

Parameters:
- ADDR_WIDTH, 20, address width of masters and RAM.
- DATA_WIDTH, 16, data width.
- READ_LATENCY, 1, cycles from the ram_rden cycle until ram_q is valid; legal values 1..3.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- m0_req  in  1  master 0 request; held until m0_ack.
- m0_we  in  1  master 0 write (1) / read (0).
- m0_addr  in  ADDR_WIDTH  master 0 address.
- m0_wdata  in  DATA_WIDTH  master 0 write data.
- m0_gnt  out  1  master 0 owns the RAM.
- m0_ack  out  1  master 0 transaction complete, one-cycle pulse.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_ack: same as master 0, for master 1.
- rdata  out  DATA_WIDTH  read data; valid in the ack cycle, held until the next read capture.
- ram_addr  out  ADDR_WIDTH  to RAM address.
- ram_data  out  DATA_WIDTH  to RAM write data.
- ram_rden  out  1  RAM read enable.
- ram_wren  out  1  RAM write enable.
- ram_q  in  DATA_WIDTH  RAM read data.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset values (async on reset_n low):
  - state = IDLE; all gnt/ack/rden/wren = 0; rdata = 0; ram_addr = 0; ram_data = 0.
  - last_grant = 1, so master 0 wins the first tie.
- All outputs are registered.
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - Requests are sampled only here.
  - One req high: that master wins.
  - Both req high: round-robin; winner = master not equal to last_grant.
  - On a win: latch winner, we, addr and wdata into internal registers; update last_grant; set gnt_winner; go to ACCESS.
  - No req: stay in IDLE.
- ACCESS (exactly 1 cycle):
  - ram_addr/ram_data driven from latched values.
  - ram_wren = latched we; ram_rden = ~latched we.
  - Write: go to DONE. Read: load wait counter = READ_LATENCY, go to WAIT.
- WAIT:
  - Strobes low; counter decrements each cycle.
  - When counter reaches 1: capture ram_q into rdata at that edge; go to DONE.
- DONE (exactly 1 cycle): ack_winner = 1; gnt_winner stays 1; next state is IDLE.
- gnt is high from ACCESS through DONE inclusive. It is cleared on entering IDLE.
- Latency, from the req-sampling edge to the ack cycle:
  - write: ack in cycle 2;
  - read: ack in cycle 2 + READ_LATENCY.
- Handshake rules:
  - Master holds req/we/addr/wdata stable until ack.
  - Master must drop req in the cycle after ack. If req is still high in IDLE, it is a new transaction (back-to-back allowed).
  - Changes to the inputs of a granted master after the IDLE sample are ignored.
- Simultaneous continuous requests alternate m0, m1, m0, ...
- A req from the losing master stays pending and is served on the next IDLE.
- ram_rden and ram_wren are never both 1. Each is high for at most one cycle per transaction.
- Reset mid-transaction: abort immediately and return to reset values. No ack is issued; the transaction is not retried. Memory content for an aborted write cycle is undefined.
- ram_addr/ram_data hold their last values outside ACCESS.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIORITY_EN.
- Defined: master 0 always wins when both request. last_grant is still maintained but ignored, so master 1 can starve.
- Undefined: round-robin as above.

Test Plan:
- Reset with both reqs low:
  - Stimulus: release reset, hold both reqs low 5 cycles.
  - Required: all outputs 0, busy = 0, no RAM strobe.
- m0 write then read, READ_LATENCY = 1:
  - Stimulus: write 16'hBEEF to 20'h00010, then read 20'h00010.
  - Required: ram_wren for exactly 1 cycle with ram_addr = 20'h00010 and ram_data = 16'hBEEF; m0_ack 2 cycles after the req sample.
  - Required (read): m0_ack 3 cycles after the req sample with rdata = 16'hBEEF.
- Contention:
  - Stimulus: m0 and m1 both hold read req continuously for 4 transactions.
  - Required: grants m0, m1, m0, m1.
  - With MEM_ARB_FIXED_PRIORITY_EN: m0 for all 4; m1_ack never asserted.
- READ_LATENCY = 3:
  - Stimulus: m1 reads an address preloaded with 16'h1234.
  - Required: ack 5 cycles after the req sample; rdata = 16'h1234.
  - Required: ram_rden high for exactly 1 cycle.
- Reset mid-read:
  - Stimulus: assert reset_n low during WAIT.
  - Required: immediately busy = 0, gnt = 0, no ack.
  - Required after release: a fresh m0 request completes normally.
- Strobe exclusivity:
  - Stimulus: run a random mix of 200 transactions from both masters.
  - Required: ram_rden & ram_wren never both 1.
  - Required: each ack is preceded by exactly one strobe; rdata matches a reference memory model.
